// File: rtl/aes192_dec_round_ctrl_if.sv
// Bundle of the sequencer's block handshakes, round-key select and round-logic hookup.
// Latency: none, wiring only.
// Backpressure: carries the s_valid/s_ready and m_valid/m_ready pairs unchanged.
interface aes192_dec_round_ctrl_if #(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [SEL_WIDTH-1:0]  key_sel;
    logic [DATA_WIDTH-1:0] rk;
    logic [DATA_WIDTH-1:0] rnd_state;
    logic                  rnd_last;
    logic [DATA_WIDTH-1:0] rnd_result;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  blk_count;

    // Sequencer side.
    modport master (
        input  s_valid, s_data, rk, rnd_result, m_ready,
        output s_ready, key_sel, rnd_state, rnd_last, m_valid, m_data, busy, blk_count
    );

    // Environment side: block source/sink, key mux and inverse-round logic.
    modport slave (
        output s_valid, s_data, rk, rnd_result, m_ready,
        input  s_ready, key_sel, rnd_state, rnd_last, m_valid, m_data, busy, blk_count
    );
endinterface

// File: rtl/aes192_dec_round_ctrl.sv
// AES-192 decrypt round sequencer: holds the cipher state and walks round keys NUM_ROUNDS..0.
// Latency: m_valid in the 13th cycle after the accept cycle; one block per 13 cycles sustained.
// Backpressure: result held while m_ready is low; a new block is taken in the output cycle only on m_ready.
module aes192_dec_round_ctrl #(
    parameter int NUM_ROUNDS = 12,
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    aes192_dec_round_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    // Key index used for the initial AddRoundKey, and the first inverse round's key.
    localparam logic [SEL_WIDTH-1:0] SEL_INIT  = SEL_WIDTH'(NUM_ROUNDS);
    localparam logic [SEL_WIDTH-1:0] SEL_FIRST = SEL_WIDTH'(NUM_ROUNDS - 1);

    logic [1:0]            fsm;
    logic [SEL_WIDTH-1:0]  rnd_cnt;
    logic [DATA_WIDTH-1:0] state_q;
    logic [CNT_WIDTH-1:0]  blk_cnt_q;

    logic in_idle;
    logic in_round;
    logic in_out;
    logic out_fire;
    logic take_ok;
    logic take_blk;
    logic last_rnd;

    // State decodes and handshake qualifiers; m_ready only reaches s_ready, never m_valid.
    always_comb begin
        in_idle  = (fsm == ST_IDLE);
        in_round = (fsm == ST_ROUND);
        in_out   = (fsm == ST_OUT);
        last_rnd = in_round && (rnd_cnt == '0);
        out_fire = in_out && bus.m_ready;
        take_ok  = !ap_rst && (in_idle || out_fire);
        take_blk = bus.s_valid && take_ok;
    end

    // Outputs decoded straight from registers (plus m_ready for s_ready).
    assign bus.s_ready   = take_ok;
    assign bus.key_sel   = in_round ? rnd_cnt : SEL_INIT;
    assign bus.rnd_last  = last_rnd;
    assign bus.rnd_state = state_q;
    assign bus.m_valid   = in_out;
    assign bus.m_data    = state_q;
    assign bus.busy      = in_round || in_out;
    assign bus.blk_count = blk_cnt_q;

    // Sequencing: accept -> NUM_ROUNDS round cycles counting down -> hold for output.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            fsm     <= ST_IDLE;
            rnd_cnt <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (take_blk) begin
                        fsm     <= ST_ROUND;
                        rnd_cnt <= SEL_FIRST;
                    end
                end
                ST_ROUND: begin
                    if (rnd_cnt == '0) begin
                        fsm <= ST_OUT;
                    end else begin
                        rnd_cnt <= rnd_cnt - SEL_WIDTH'(1);
                    end
                end
                ST_OUT: begin
                    // Back-to-back: the block leaving and the block arriving share this edge.
                    if (take_blk) begin
                        fsm     <= ST_ROUND;
                        rnd_cnt <= SEL_FIRST;
                    end else if (out_fire) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: begin
                    fsm     <= ST_IDLE;
                    rnd_cnt <= '0;
                end
            endcase
        end
    end

    // Cipher state: whitening with the last round key on accept, then one inverse round per cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= '0;
        end else if (take_blk) begin
            state_q <= bus.s_data ^ bus.rk;
        end else if (in_round) begin
            state_q <= bus.rnd_result;
        end
    end

    // Completed-block counter, free-running wrap.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            blk_cnt_q <= '0;
        end else if (out_fire) begin
            blk_cnt_q <= blk_cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_aes192_dec_round_ctrl.sv
// Bench for the AES-192 decrypt round sequencer: supplies key mux and inverse round,
// compares every cycle against a block-level decrypt model, plus directed scenarios.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_aes192_dec_round_ctrl;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    aes192_dec_round_ctrl_if #(.SEL_WIDTH(4), .DATA_WIDTH(128), .CNT_WIDTH(16)) bus ();
    aes192_dec_round_ctrl_if #(.SEL_WIDTH(4), .DATA_WIDTH(128), .CNT_WIDTH(2))  bus2 ();

    aes192_dec_round_ctrl #(.NUM_ROUNDS(12), .SEL_WIDTH(4), .DATA_WIDTH(128), .CNT_WIDTH(16)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    aes192_dec_round_ctrl #(.NUM_ROUNDS(12), .SEL_WIDTH(4), .DATA_WIDTH(128), .CNT_WIDTH(2)) dut2 (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus2)
    );

    localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]   sb  [0:255];
    logic [7:0]   isb [0:255];
    logic [127:0] rkeys [0:12];

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event never occurred within bound", nm);
    endtask

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gm(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r + 4*((c + r) % 4)] = isb[b[r + 4*c]];
        for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
                t[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
                t[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
                t[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    // Whole-block model: plaintext of a ciphertext under KEY.
    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rkeys[12];
        for (int k = 11; k >= 0; k--) s = inv_round(s, rkeys[k], k == 0);
        return s;
    endfunction

    task automatic build_tables();
        logic [31:0] w [0:51];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 256; i++) begin
            sb[i] = sbox_calc(8'(i));
            isb[sb[i]] = 8'(i);
        end
        rc = 8'h01;
        for (int i = 0; i < 52; i++) begin
            if (i < 6) begin
                w[i] = KEY[191-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % 6 == 0) begin
                    tmp = {tmp[23:0], tmp[31:24]};
                    tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                    rc = xt(rc);
                end
                w[i] = w[i-6] ^ tmp;
            end
        end
        for (int k = 0; k < 13; k++) rkeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Environment: round-key mux and inverse-round logic for the main instance.
    assign bus.rk         = (bus.key_sel <= 4'd12) ? rkeys[bus.key_sel] : 128'h0;
    assign bus.rnd_result = inv_round(bus.rnd_state, bus.rk, bus.rnd_last);

    // Trivial round logic for the counter-wrap instance.
    assign bus2.rk         = {32{bus2.key_sel}};
    assign bus2.rnd_result = bus2.rnd_state ^ bus2.rk;

    // ---------------- per-cycle comparison against the block model ----------------
    bit           chk_en = 1'b0;
    bit           pend   = 1'b0;
    int           pend_cyc;
    logic [127:0] pend_pt;
    int           mcount = 0;
    int           age;
    bit           exp_mv;
    bit           exp_srdy;
    int           obs_cyc [$];
    logic [127:0] obs_dat [$];

    always @(negedge ap_clk) begin
        if (chk_en) begin
            age      = cyc - pend_cyc;
            exp_mv   = pend && (age >= 13);
            exp_srdy = !ap_rst && (!pend || (exp_mv && bus.m_ready));
            check("mon_m_valid",  bus.m_valid, exp_mv);
            check("mon_s_ready",  bus.s_ready, exp_srdy);
            check("mon_busy",     bus.busy, pend);
            check("mon_key_sel",  bus.key_sel, (pend && age >= 1 && age <= 12) ? 12 - age : 12);
            check("mon_rnd_last", bus.rnd_last, pend && age == 12);
            check("mon_blk_count", bus.blk_count, mcount[15:0]);
            if (exp_mv) check("mon_m_data", bus.m_data, pend_pt);
            if (ap_rst) begin
                pend   = 1'b0;
                mcount = 0;
            end else begin
                if (exp_mv && bus.m_ready) begin
                    pend = 1'b0;
                    mcount++;
                    obs_cyc.push_back(cyc);
                    obs_dat.push_back(bus.m_data);
                end
                if (bus.s_valid && exp_srdy) begin
                    pend     = 1'b1;
                    pend_cyc = cyc;
                    pend_pt  = model_dec(bus.s_data);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_accept(input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            if (bus.s_ready) return;
        end
        fail(nm);
    endtask

    task automatic wait_mvalid(input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            if (bus.m_valid) return;
        end
        fail(nm);
    endtask

    task automatic send(input logic [127:0] d, input string nm);
        @(posedge ap_clk); #1;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        wait_accept(nm);
        @(posedge ap_clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic seq_check(input int i);
        check($sformatf("seq_key_sel[%0d]", i),  bus.key_sel, (i <= 12) ? 12 - i : 12);
        check($sformatf("seq_rnd_last[%0d]", i), bus.rnd_last, i == 12);
        check($sformatf("seq_m_valid[%0d]", i),  bus.m_valid, i == 13);
    endtask

    logic [127:0] blk4 [4];
    int           exp_cnt;
    int           n0;
    int           seen;
    bit           found;
    int           wrap_exp [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b0;
        bus2.s_valid = 1'b0;
        bus2.s_data  = '0;
        bus2.m_ready = 1'b1;
        build_tables();

        // Pin the model with literals.
        check("pin_sbox_00", sb[8'h00], 8'h63);
        check("pin_sbox_53", sb[8'h53], 8'hed);
        check("pin_isbox_16", isb[8'h16], 8'hff);
        check("pin_model_fips", model_dec(CT), PT);

        // Reset behaviour.
        @(negedge ap_clk);
        check("rst_s_ready_during", bus.s_ready, 1'b0);
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        chk_en = 1'b1;
        @(negedge ap_clk);
        check("rst_s_ready", bus.s_ready, 1'b1);
        check("rst_key_sel", bus.key_sel, 12);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_busy",    bus.busy, 1'b0);
        check("rst_blk_count", bus.blk_count, 0);
        check("rst_rnd_last", bus.rnd_last, 1'b0);
        check("rst_rnd_state", bus.rnd_state, 128'h0);

        // FIPS vector, exact latency and key-select sequence.
        @(posedge ap_clk); #1;
        bus.s_data  = CT;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        wait_accept("t1_accept");
        seq_check(0);
        @(posedge ap_clk); #1;
        bus.s_valid = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge ap_clk);
            seq_check(i);
            if (i == 13) check("t1_plaintext", bus.m_data, PT);
        end
        @(negedge ap_clk);
        check("t1_blk_count", bus.blk_count, 1);
        exp_cnt = 1;

        // Backpressure with a waiting block.
        @(posedge ap_clk); #1;
        bus.m_ready = 1'b0;
        send(128'h000102030405060708090a0b0c0d0e0f, "t3_accept_a");
        wait_mvalid("t3_mvalid_a");
        @(posedge ap_clk); #1;
        bus.s_data  = 128'hfedcba9876543210f0e1d2c3b4a59687;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("t3_hold_data", bus.m_data, model_dec(128'h000102030405060708090a0b0c0d0e0f));
            check("t3_hold_s_ready", bus.s_ready, 1'b0);
            check("t3_hold_count", bus.blk_count, exp_cnt);
        end
        @(posedge ap_clk); #1;
        bus.m_ready = 1'b1;
        @(negedge ap_clk);
        check("t3_same_cycle_ready", bus.s_ready, 1'b1);
        @(posedge ap_clk); #1;
        bus.s_valid = 1'b0;
        exp_cnt++;
        @(negedge ap_clk);
        check("t3_b_in_round", bus.key_sel, 11);
        check("t3_count_after", bus.blk_count, exp_cnt);
        wait_mvalid("t3_mvalid_b");
        check("t3_data_b", bus.m_data, model_dec(128'hfedcba9876543210f0e1d2c3b4a59687));
        @(negedge ap_clk);
        exp_cnt++;
        check("t3_count_b", bus.blk_count, exp_cnt);

        // Back-to-back stream of four blocks.
        blk4[0] = PT;
        blk4[1] = CT;
        blk4[2] = 128'h0;
        blk4[3] = {128{1'b1}};
        n0 = obs_cyc.size();
        for (int j = 0; j < 4; j++) begin
            @(posedge ap_clk); #1;
            bus.s_data  = blk4[j];
            bus.s_valid = 1'b1;
            wait_accept("t4_accept");
        end
        @(posedge ap_clk); #1;
        bus.s_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge ap_clk);
            if (obs_cyc.size() >= n0 + 4) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            fail("t4_outputs");
        end else begin
            for (int k = 0; k < 4; k++)
                check($sformatf("t4_data[%0d]", k), obs_dat[n0+k], model_dec(blk4[k]));
            for (int k = 1; k < 4; k++)
                check($sformatf("t4_gap[%0d]", k), obs_cyc[n0+k] - obs_cyc[n0+k-1], 13);
        end
        @(negedge ap_clk);
        exp_cnt += 4;
        check("t4_blk_count", bus.blk_count, exp_cnt);

        // Reset in the middle of a block.
        send(128'h0123456789abcdef0123456789abcdef, "t5_accept");
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (bus.key_sel == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail("t5_key_sel_7");
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("t5_key_sel_at_rst", bus.key_sel, 6);
        check("t5_s_ready_in_rst", bus.s_ready, 1'b0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("t5_s_ready_after", bus.s_ready, 1'b1);
        check("t5_key_sel_after", bus.key_sel, 12);
        check("t5_busy_after", bus.busy, 1'b0);
        check("t5_count_after", bus.blk_count, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (bus.m_valid) seen++;
        end
        check("t5_no_output", seen, 0);
        send(CT, "t5_accept_next");
        wait_mvalid("t5_mvalid_next");
        check("t5_data_next", bus.m_data, PT);
        @(negedge ap_clk);
        check("t5_count_next", bus.blk_count, 1);

        // Counter wrap on the 2-bit instance.
        wrap_exp = '{1, 2, 3, 0, 1};
        for (int j = 0; j < 5; j++) begin
            @(posedge ap_clk); #1;
            bus2.s_data  = 128'(j);
            bus2.s_valid = 1'b1;
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge ap_clk);
                if (bus2.s_ready) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) fail("t6_accept");
            @(posedge ap_clk); #1;
            bus2.s_valid = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge ap_clk);
                if (bus2.m_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) fail("t6_mvalid");
            @(negedge ap_clk);
            check($sformatf("t6_wrap[%0d]", j), bus2.blk_count, wrap_exp[j]);
        end

        repeat (2) @(negedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
